// File: rtl/product_accumulator_if.sv
// Product-in / sum-out bus between the multiplier output register and the accumulator.
interface product_accumulator_if #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 12
);
    logic [PROD_W-1:0] prod_i;
    logic              prod_valid_i;
    logic              clear_i;
    logic [ACC_W-1:0]  acc_o;
    logic              acc_valid_o;
    logic              acc_ready_i;
    logic              ovf_o;
    logic              drop_o;
    logic              busy_o;

    modport master (
        output prod_i, prod_valid_i, clear_i, acc_ready_i,
        input  acc_o, acc_valid_o, ovf_o, drop_o, busy_o
    );

    modport slave (
        input  prod_i, prod_valid_i, clear_i, acc_ready_i,
        output acc_o, acc_valid_o, ovf_o, drop_o, busy_o
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive valid products with saturation; presents each sum on valid/ready.
module product_accumulator #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned COUNT  = 4
) (
    input logic                  clk,
    input logic                  rst,
    product_accumulator_if.slave bus
);
    localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic               acc_valid_q, acc_valid_d;
    logic               ovf_q, ovf_d;
    logic               drop_q, drop_d;

    logic [SUM_W-1:0]   sum;
    logic               run_ovf;
    logic [ACC_W-1:0]   sat;
    logic               take;

    // Saturating add of the incoming product onto the running sum.
    always_comb begin
        sum     = {1'b0, acc_q} + SUM_W'(bus.prod_i);
        run_ovf = sum[ACC_W] | ovf_acc_q;
        sat     = run_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    // Next-state and datapath control; a HOLD handshake frees the slot for a same-cycle product.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        take        = 1'b0;

        if (bus.clear_i) begin
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
            acc_valid_d = 1'b0;
            ovf_d       = 1'b0;
            drop_d      = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    take = bus.prod_valid_i;
                end
                HOLD: begin
                    if (bus.acc_ready_i) begin
                        acc_valid_d = 1'b0;
                        state_d     = ACCUM;
                        take        = bus.prod_valid_i;
                    end else if (bus.prod_valid_i) begin
                        drop_d = 1'b1;
                    end
                end
                default: state_d = ACCUM;
            endcase

            if (take) begin
                if (cnt_q == CNT_LAST) begin
                    acc_out_d   = sat;
                    ovf_d       = run_ovf;
                    acc_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_acc_d   = 1'b0;
                    state_d     = HOLD;
                end else begin
                    acc_d     = sat;
                    cnt_d     = cnt_q + CNT_W'(1);
                    ovf_acc_d = run_ovf;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.acc_o       = acc_out_q;
    assign bus.acc_valid_o = acc_valid_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.drop_o      = drop_q;
    assign bus.busy_o      = (cnt_q != '0) | acc_valid_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Three configurations driven with shared stimulus and checked against a run-level model.
module tb_product_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] prod;
    logic       pv;
    logic       clr;
    logic       rdy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model configuration: inst0 COUNT=4/ACC_W=12, inst1 COUNT=2/ACC_W=8, inst2 COUNT=1/ACC_W=8.
    int unsigned cfg_count [3] = '{4, 2, 1};
    int unsigned cfg_max   [3] = '{4095, 255, 255};

    // Model state: products summed so far in the open run, and the presented result.
    int unsigned m_sum  [3];
    int unsigned m_n    [3];
    int unsigned m_res  [3];
    bit          m_pend [3];
    bit          m_ovf  [3];
    bit          m_drop [3];

    product_accumulator_if #(.PROD_W(8), .ACC_W(12)) if0 ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(8))  if1 ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(8))  if2 ();

    assign if0.prod_i = prod;  assign if0.prod_valid_i = pv;
    assign if0.clear_i = clr;  assign if0.acc_ready_i = rdy;
    assign if1.prod_i = prod;  assign if1.prod_valid_i = pv;
    assign if1.clear_i = clr;  assign if1.acc_ready_i = rdy;
    assign if2.prod_i = prod;  assign if2.prod_valid_i = pv;
    assign if2.clear_i = clr;  assign if2.acc_ready_i = rdy;

    product_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    product_accumulator #(.PROD_W(8), .ACC_W(8),  .COUNT(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    product_accumulator #(.PROD_W(8), .ACC_W(8),  .COUNT(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge of the reference model.
    task automatic model_step(input bit v, input int unsigned p, input bit c, input bit r, input bit rs);
        for (int k = 0; k < 3; k++) begin
            if (rs) begin
                m_sum[k] = 0; m_n[k] = 0; m_res[k] = 0;
                m_pend[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
            end else if (c) begin
                m_sum[k] = 0; m_n[k] = 0;
                m_pend[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
            end else if (m_pend[k] && !r) begin
                if (v) m_drop[k] = 1;
            end else begin
                m_pend[k] = 0;
                if (v) begin
                    m_sum[k] += p;
                    m_n[k]++;
                    if (m_n[k] == cfg_count[k]) begin
                        m_pend[k] = 1;
                        m_ovf[k]  = (m_sum[k] > cfg_max[k]);
                        m_res[k]  = m_ovf[k] ? cfg_max[k] : m_sum[k];
                        m_sum[k]  = 0;
                        m_n[k]    = 0;
                    end
                end
            end
        end
    endtask

    function automatic int unsigned exp_busy(input int k);
        return ((m_n[k] != 0) || m_pend[k]) ? 1 : 0;
    endfunction

    task automatic check_all();
        check("acc0",   32'(if0.acc_o),       m_res[0]);
        check("valid0", 32'(if0.acc_valid_o), 32'(m_pend[0]));
        check("ovf0",   32'(if0.ovf_o),       32'(m_ovf[0]));
        check("drop0",  32'(if0.drop_o),      32'(m_drop[0]));
        check("busy0",  32'(if0.busy_o),      exp_busy(0));
        check("acc1",   32'(if1.acc_o),       m_res[1]);
        check("valid1", 32'(if1.acc_valid_o), 32'(m_pend[1]));
        check("ovf1",   32'(if1.ovf_o),       32'(m_ovf[1]));
        check("drop1",  32'(if1.drop_o),      32'(m_drop[1]));
        check("busy1",  32'(if1.busy_o),      exp_busy(1));
        check("acc2",   32'(if2.acc_o),       m_res[2]);
        check("valid2", 32'(if2.acc_valid_o), 32'(m_pend[2]));
        check("ovf2",   32'(if2.ovf_o),       32'(m_ovf[2]));
        check("drop2",  32'(if2.drop_o),      32'(m_drop[2]));
        check("busy2",  32'(if2.busy_o),      exp_busy(2));
    endtask

    // Drive one cycle of inputs, advance model and DUT one edge, then compare.
    task automatic step(input bit v, input int unsigned p, input bit c, input bit r, input bit rs);
        pv = v; prod = 8'(p); clr = c; rdy = r; rst = rs;
        @(posedge clk);
        model_step(v, p, c, r, rs);
        #1;
        check_all();
    endtask

    initial begin
        pv = 0; prod = '0; clr = 0; rdy = 0; rst = 1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_acc0",  32'(if0.acc_o), 0);
        check("rst_busy0", 32'(if0.busy_o), 0);

        // Basic sum 4 x 225.
        for (int i = 0; i < 4; i++) step(1, 225, 0, 1, 0);
        check("basic_acc",   32'(if0.acc_o), 900);
        check("basic_valid", 32'(if0.acc_valid_o), 1);
        check("basic_ovf",   32'(if0.ovf_o), 0);
        step(0, 0, 0, 1, 0);
        check("basic_busy",  32'(if0.busy_o), 0);

        // Backpressure and drop.
        step(0, 0, 1, 0, 0);
        step(1, 10, 0, 0, 0); step(1, 20, 0, 0, 0);
        step(1, 30, 0, 0, 0); step(1, 40, 0, 0, 0);
        step(1, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        check("bp_acc",  32'(if0.acc_o), 100);
        check("bp_drop", 32'(if0.drop_o), 1);
        step(0, 0, 0, 1, 0);
        check("bp_accepted", 32'(if0.acc_valid_o), 0);
        check("bp_idle",     32'(if0.busy_o), 0);

        // Same-cycle handshake plus product.
        step(0, 0, 1, 0, 0);
        step(1, 10, 0, 0, 0); step(1, 20, 0, 0, 0);
        step(1, 30, 0, 0, 0); step(1, 40, 0, 0, 0);
        step(1, 7, 0, 1, 0);
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        check("same_acc",  32'(if0.acc_o), 10);
        check("same_drop", 32'(if0.drop_o), 0);

        // Saturation on the 8-bit COUNT=2 instance.
        step(0, 0, 1, 1, 0);
        step(1, 200, 0, 1, 0); step(1, 100, 0, 1, 0);
        check("sat_acc", 32'(if1.acc_o), 255);
        check("sat_ovf", 32'(if1.ovf_o), 1);
        step(1, 3, 0, 1, 0); step(1, 4, 0, 1, 0);
        check("sat_next_acc", 32'(if1.acc_o), 7);
        check("sat_next_ovf", 32'(if1.ovf_o), 0);

        // Clear mid-run with a coincident strobe.
        step(0, 0, 1, 1, 0);
        step(1, 50, 0, 1, 0); step(1, 50, 0, 1, 0);
        step(1, 99, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
        check("clr_acc", 32'(if0.acc_o), 4);

        // Reset while holding a result.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("rst_hold_valid", 32'(if0.acc_valid_o), 0);
        check("rst_hold_acc",   32'(if0.acc_o), 0);
        check("rst_hold_busy",  32'(if0.busy_o), 0);

        // COUNT=1 back-to-back results.
        step(1, 9, 0, 1, 0);
        check("c1_first", 32'(if2.acc_o), 9);
        step(1, 8, 0, 1, 0);
        check("c1_second", 32'(if2.acc_o), 8);
        step(1, 7, 0, 1, 0);
        check("c1_third", 32'(if2.acc_o), 7);
        check("c1_valid", 32'(if2.acc_valid_o), 1);
        check("c1_drop",  32'(if2.drop_o), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7),
                 $urandom_range(0, 255),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the 4-bit shift/add multiplier's registered product. Sums a fixed number of consecutive valid products into a wider accumulator and presents each completed sum on a valid/ready output. Saturates instead of wrapping on overflow, and reports overflow and dropped products as sticky flags. Sits between the multiplier output register and the result/readout logic.

## Interface

Parameters:
- PROD_W, 8, width of incoming product (2 × multiplier operand width)
- ACC_W, 12, accumulator/result width; must be ≥ PROD_W
- COUNT, 4, products summed per result; legal range 1..16

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- prod_i  in  PROD_W  unsigned product from multiplier output register
- prod_valid_i  in  1  prod_i holds a new product this cycle; single-cycle strobe per product
- clear_i  in  1  synchronous abort: discard partial sum and any pending result, clear flags
- acc_o  out  ACC_W  completed sum; stable while acc_valid_o=1
- acc_valid_o  out  1  acc_o holds a completed result
- acc_ready_i  in  1  consumer accepts result when acc_valid_o & acc_ready_i
- ovf_o  out  1  the result on acc_o saturated
- drop_o  out  1  sticky: a product arrived while a result was pending and was discarded
- busy_o  out  1  partial sum in progress (count ≠ 0) or result pending

## Operation

- Internal state: acc (ACC_W), cnt (0..COUNT-1), ovf_acc (1), and FSM {ACCUM, HOLD}.
- Unsigned add: sum = acc + zero-extended prod_i, computed at ACC_W+1 bits. If bit ACC_W is set, or ovf_acc is already set, acc becomes 2^ACC_W−1 and ovf_acc is set.
- ACCUM, prod_valid_i=1, cnt < COUNT−1: acc ← sat(sum), cnt ← cnt+1.
- ACCUM, prod_valid_i=1, cnt = COUNT−1:
  - acc_o ← sat(sum), ovf_o ← overflow of this run, acc_valid_o ← 1.
  - acc ← 0, cnt ← 0, ovf_acc ← 0.
  - Go to HOLD.
- ACCUM, prod_valid_i=0: hold all state.
- HOLD: acc_o, ovf_o and acc_valid_o are held.
  - prod_valid_i=1 without a handshake in the same cycle: the product is discarded and drop_o ← 1.
- HOLD, handshake (acc_valid_o & acc_ready_i):
  - acc_valid_o ← 0, go to ACCUM.
  - If prod_valid_i=1 in the same cycle, that product starts the next run: acc ← prod_i, cnt ← 1. With COUNT=1 it instead produces the next result directly and the FSM stays in HOLD.
- COUNT=1: every accepted product becomes a result.
- clear_i (priority below rst, above everything else):
  - acc ← 0, cnt ← 0, ovf_acc ← 0, acc_valid_o ← 0, ovf_o ← 0, drop_o ← 0, FSM ← ACCUM.
  - A prod_valid_i in the same cycle is ignored.
- busy_o = (cnt ≠ 0) | acc_valid_o. This is combinational from registered state.

## Timing

- Reset values (rst=1 at an edge): acc_o=0, acc_valid_o=0, ovf_o=0, drop_o=0, busy_o=0; acc=0, cnt=0, FSM=ACCUM.
- Reset mid-run or while HOLD discards all state. No result is emitted.
- Latency: acc_valid_o rises on the edge that samples the COUNT-th prod_valid_i, i.e. 1 cycle after the final product is presented.
- Throughput: one product per cycle. Back-to-back results need no gap when acc_ready_i is held high (same-cycle handshake plus new product).
- acc_valid_o never drops without a handshake, clear_i or rst. acc_o and ovf_o do not change while acc_valid_o=1.
- No combinational path from any input to any output except through registered state (acc_ready_i does not feed outputs).
- Upstream contract: prod_valid_i asserts the cycle after the multiplier's operands are registered plus one, aligned with its output register. This block does not check alignment.

## Test plan

- Basic sum, COUNT=4, ACC_W=12:
  - Stimulus: four strobes of prod_i=225 (15×15), acc_ready_i=1.
  - Response: acc_o=900 and acc_valid_o=1 exactly 1 cycle after the 4th strobe; ovf_o=0; result held 1 cycle, then busy_o=0.
- Backpressure and drop:
  - Stimulus: complete a run of 10, 20, 30, 40 with acc_ready_i=0; send one extra strobe prod_i=5; hold ready low 3 cycles, then raise it.
  - Response: acc_o=100 stable throughout, drop_o=1 after the extra strobe, result accepted when ready rises; next run starts from 0.
- Same-cycle handshake and product:
  - Stimulus: in HOLD with acc_o=100, acc_ready_i=1 and prod_valid_i=1 with prod_i=7 in the same cycle, then three strobes of 1.
  - Response: next acc_o=10, with no dropped product and drop_o unchanged.
- Saturation, ACC_W=8, COUNT=2:
  - Stimulus: products 200 then 100.
  - Response: acc_o=255, ovf_o=1. The next run of 3, 4 gives acc_o=7, ovf_o=0.
- Clear and reset mid-operation:
  - Stimulus: two of four products (50, 50), then clear_i=1 coincident with a strobe; then four strobes of 1. Separately, assert rst while in HOLD.
  - Response: after clear, acc_o=4 (no residue of 100). After rst, all outputs are 0 the next cycle and busy_o=0.
- COUNT=1:
  - Stimulus: strobes 9, 8, 7 on consecutive cycles with acc_ready_i=1.
  - Response: results 9, 8, 7 on consecutive cycles, acc_valid_o continuously high, drop_o=0.
